packet_fifo: RTL and testbench

- Store-and-forward frame FIFO for the Ethernet RX path; sits between the MAC receive datapath and the frame parser/UDP stack.
- Write side has no backpressure. Beats are written speculatively. A frame becomes visible to the reader only when its last beat is accepted. Aborted or overflowing frames are rewound and discarded whole.
- Read side is first-word-fall-through with valid/ready and per-beat end-of-frame flag.

---
 rtl/packet_fifo_pkg.sv | 15 +
 rtl/packet_fifo_ram.sv | 24 ++
 rtl/packet_fifo.sv | 154 +++++++++++++++
 tb/tb_packet_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_fifo_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
package packet_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } wr_state_e;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/packet_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset.
module packet_fifo_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/packet_fifo.sv
// Store-and-forward frame FIFO: speculative writes, commit on last beat,
// whole-frame rewind on abort or overflow, FWFT valid/ready read side.
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned MAX_DEPTH  = 2048,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [DATA_SIZE-1:0]        wr_data,
  input  logic                        wr_last,
  input  logic                        wr_abort,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATA_SIZE-1:0]        rd_data,
  output logic                        rd_last,
  output logic [$clog2(MAX_DEPTH):0]  fill_level,
  output logic [$clog2(MAX_DEPTH):0]  frame_count,
  output logic [DROP_CNT_W-1:0]       drop_count,
  output logic                        overflow
);

  localparam int unsigned Addr = $clog2(MAX_DEPTH);
  localparam int unsigned Pw   = ptr_width(MAX_DEPTH);
  localparam logic [Pw-1:0] FullLvl = Pw'(MAX_DEPTH);

  if ((MAX_DEPTH < 4) || ((MAX_DEPTH & (MAX_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("packet_fifo: MAX_DEPTH must be a power of two >= 4");
  end

  wr_state_e r_state, w_state_d;
  logic [Pw-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [Pw-1:0] r_commit_ptr, w_commit_ptr_d;
  logic [Pw-1:0] r_rd_ptr;
  logic [Pw-1:0] r_frame_count;
  logic [DROP_CNT_W-1:0] r_drop_count;
  logic r_overflow;

  logic w_we, w_commit, w_drop, w_ovf;
  logic w_pop, w_full;
  logic [Pw-1:0] w_used;
  logic [DATA_SIZE:0] w_rd_word;

  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign rd_valid = (r_rd_ptr != r_commit_ptr);
  assign w_pop    = rd_valid & rd_ready;
  // A slot freed by this cycle's pop may be refilled by this cycle's write.
  assign w_full   = (w_used == FullLvl) && !w_pop;

  packet_fifo_ram #(
    .WIDTH (DATA_SIZE + 1),
    .DEPTH (MAX_DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[Addr-1:0]),
    .i_wdata ({wr_last, wr_data}),
    .i_raddr (r_rd_ptr[Addr-1:0]),
    .o_rdata (w_rd_word)
  );

  assign rd_data = w_rd_word[DATA_SIZE-1:0];
  assign rd_last = w_rd_word[DATA_SIZE];

  always_comb begin
    w_state_d      = r_state;
    w_wr_ptr_d     = r_wr_ptr;
    w_commit_ptr_d = r_commit_ptr;
    w_we           = 1'b0;
    w_commit       = 1'b0;
    w_drop         = 1'b0;
    w_ovf          = 1'b0;
    unique case (r_state)
      StIdle, StRecv: begin
        if (wr_abort) begin
          // An abort in IDLE only counts when it throws away a beat.
          w_drop     = (r_state == StRecv) || wr_valid;
          w_wr_ptr_d = r_commit_ptr;
          w_state_d  = StIdle;
        end else if (wr_valid) begin
          if (w_full) begin
            w_drop     = 1'b1;
            w_ovf      = 1'b1;
            w_wr_ptr_d = r_commit_ptr;
            w_state_d  = wr_last ? StIdle : StDrop;
          end else begin
            w_we       = 1'b1;
            w_wr_ptr_d = r_wr_ptr + 1'b1;
            if (wr_last) begin
              w_commit       = 1'b1;
              w_commit_ptr_d = r_wr_ptr + 1'b1;
              w_state_d      = StIdle;
            end else begin
              w_state_d = StRecv;
            end
          end
        end
      end
      StDrop: begin
        if (wr_abort || (wr_valid && wr_last)) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_commit_ptr <= w_commit_ptr_d;
      r_overflow   <= w_ovf;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_count <= '0;
    end else begin
      unique case ({w_commit, w_pop && rd_last})
        2'b10:   r_frame_count <= r_frame_count + 1'b1;
        2'b01:   r_frame_count <= r_frame_count - 1'b1;
        default: r_frame_count <= r_frame_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign fill_level  = w_used;
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_packet_fifo.sv
// Scoreboard bench for packet_fifo at MAX_DEPTH=16.
module tb_packet_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned MD = 16;
  localparam int unsigned DC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_last = 1'b0;
  logic wr_abort = 1'b0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic rd_last;
  logic [$clog2(MD):0] fill_level;
  logic [$clog2(MD):0] frame_count;
  logic [DC-1:0] drop_count;
  logic overflow;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  logic [DW:0] exp_q[$];

  packet_fifo #(
    .DATA_SIZE  (DW),
    .MAX_DEPTH  (MD),
    .DROP_CNT_W (DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_abort    (wr_abort),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .fill_level  (fill_level),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted read word must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rd_valid && rd_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {23'd0, rd_last, rd_data}, 32'hFFFF_FFFF);
        end else begin
          check("rd_word", {23'd0, rd_last, rd_data}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic abort);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    wr_abort = abort;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_abort = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic drain(input int n);
    int target;
    bit done;
    target   = pop_cnt + n;
    done     = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (pop_cnt >= target) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int max_fc;
    int target;

    // Reset state.
    #2;
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_frames", 32'(frame_count), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 4-beat frame not visible until its last beat.
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      push_exp(d, i == 3);
      beat(d, i == 3, 1'b0);
      if (i < 3) check("t1_hidden", {31'd0, rd_valid}, 32'd0);
    end
    check("t1_visible", {31'd0, rd_valid}, 32'd1);
    check("t1_frames", 32'(frame_count), 32'd1);
    check("t1_fill", 32'(fill_level), 32'd4);
    drain(4);
    check("t1_frames_after", 32'(frame_count), 32'd0);

    // Abort with a concurrent 4th beat.
    for (int i = 0; i < 3; i++) beat(8'hB0 + 8'(i), 1'b0, 1'b0);
    check("t2_fill_open", 32'(fill_level), 32'd3);
    beat(8'hB3, 1'b0, 1'b1);
    check("t2_fill", 32'(fill_level), 32'd0);
    check("t2_drops", 32'(drop_count), 32'd1);
    check("t2_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("t2_ovf", {31'd0, overflow}, 32'd0);
    push_exp(8'hC0, 1'b0);
    push_exp(8'hC1, 1'b1);
    beat(8'hC0, 1'b0, 1'b0);
    beat(8'hC1, 1'b1, 1'b0);
    check("t2_frames", 32'(frame_count), 32'd1);
    drain(2);

    // Overflow: 10 words held, 8-beat frame only has room for 6.
    for (int i = 0; i < 10; i++) begin
      d = 8'hD0 + 8'(i);
      push_exp(d, i == 9);
      beat(d, i == 9, 1'b0);
    end
    check("t3_fill10", 32'(fill_level), 32'd10);
    for (int i = 0; i < 8; i++) begin
      beat(8'hE0 + 8'(i), i == 7, 1'b0);
      check($sformatf("t3_ovf_beat%0d", i + 1), {31'd0, overflow}, {31'd0, i == 6});
    end
    check("t3_drops", 32'(drop_count), 32'd2);
    check("t3_fill", 32'(fill_level), 32'd10);
    check("t3_frames", 32'(frame_count), 32'd1);
    drain(10);
    check("t3_fill_after", 32'(fill_level), 32'd0);

    // Back-to-back single-beat frames with continuous reads.
    target   = pop_cnt + 5;
    max_fc   = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'hF0 + 8'(i);
      push_exp(d, 1'b1);
      beat(d, 1'b1, 1'b0);
      if (int'(frame_count) > max_fc) max_fc = int'(frame_count);
    end
    for (int c = 0; c < 20 && pop_cnt < target; c++) begin
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    check("t4_pops", 32'(pop_cnt), 32'(target));
    check("t4_max_frames_le2", {31'd0, max_fc <= 2}, 32'd1);
    check("t4_frames", 32'(frame_count), 32'd0);

    // Full FIFO: a pop frees the slot for a same-cycle write.
    for (int i = 0; i < 16; i++) begin
      d = 8'h40 + 8'(i);
      push_exp(d, i == 15);
      beat(d, i == 15, 1'b0);
    end
    check("t5_fill_full", 32'(fill_level), 32'd16);
    rd_ready = 1'b1;
    beat(8'h90, 1'b0, 1'b0);
    rd_ready = 1'b0;
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    check("t5_fill", 32'(fill_level), 32'd16);
    wr_abort = 1'b1;
    @(posedge clk); #1;
    wr_abort = 1'b0;
    check("t5_drops", 32'(drop_count), 32'd3);
    drain(15);
    check("t5_fill_after", 32'(fill_level), 32'd0);

    // Asynchronous reset mid-frame with two frames queued.
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h12, 1'b1, 1'b0);
    beat(8'h13, 1'b1, 1'b0);
    beat(8'h14, 1'b0, 1'b0);
    check("t6_frames", 32'(frame_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("t6_fill", 32'(fill_level), 32'd0);
    check("t6_frames_rst", 32'(frame_count), 32'd0);
    check("t6_drops", 32'(drop_count), 32'd0);
    check("t6_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    push_exp(8'h21, 1'b0);
    push_exp(8'h22, 1'b1);
    beat(8'h21, 1'b0, 1'b0);
    beat(8'h22, 1'b1, 1'b0);
    check("t6_frames_new", 32'(frame_count), 32'd1);
    drain(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
